alarm_ctrl_fsm: RTL

ALARM_CTRL_FSM -- requirements
Module: alarm_ctrl_fsm

---
 rtl/alarm_ctrl_pkg.sv | 24 ++
 rtl/alarm_ctrl_fsm_shreg.sv | 34 +++
 rtl/alarm_ctrl_fsm.sv | 139 +++++++++++++
 3 files changed

// File: rtl/alarm_ctrl_pkg.sv
// Shared encodings and constants for the alarm clock key controller.
package alarm_ctrl_pkg;

  typedef enum logic [1:0] {
    StShowTime  = 2'd0,
    StKeyEntry  = 2'd1,
    StShowAlarm = 2'd2
  } state_e;

  localparam logic [3:0]  KEY_ALARM    = 4'hA;
  localparam logic [3:0]  KEY_TIME     = 4'hB;
  localparam int unsigned TIMEOUT_SECS = 10;
  localparam int unsigned MAX_HOUR     = 23;

  // True when the four buffered digits form a legal 24-hour HH:MM.
  function automatic logic time_valid(input logic [3:0] ms_hr, input logic [3:0] ls_hr,
                                      input logic [3:0] ms_min, input logic [3:0] ls_min);
    int unsigned hours;
    hours = 32'(ms_hr) * 10 + 32'(ls_hr);
    return (ms_hr <= 4'd2) && (ls_hr <= 4'd9) && (ms_min <= 4'd5) && (ls_min <= 4'd9) &&
           (hours <= MAX_HOUR);
  endfunction

endpackage

// File: rtl/alarm_ctrl_fsm_shreg.sv
// Four-digit entry buffer; new digits enter at ls_min and push older ones left.
module alarm_key_shreg (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       shift,
  input  logic [3:0] digit,
  output logic [3:0] ms_hr,
  output logic [3:0] ls_hr,
  output logic [3:0] ms_min,
  output logic [3:0] ls_min
);

  logic [15:0] buf_q, buf_d;

  // Clear and shift together start a fresh entry with the first digit.
  always_comb begin
    buf_d = buf_q;
    if (clear) buf_d = '0;
    if (shift) buf_d = {buf_d[11:0], digit};
  end

  // Buffer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) buf_q <= '0;
    else       buf_q <= buf_d;
  end

  assign ms_hr  = buf_q[15:12];
  assign ls_hr  = buf_q[11:8];
  assign ms_min = buf_q[7:4];
  assign ls_min = buf_q[3:0];

endmodule

// File: rtl/alarm_ctrl_fsm.sv
// Alarm clock key-entry controller: show time, key entry, show alarm.
// Define ALARM_CTRL_TIMEOUT_EN to return to time display after ten idle seconds.
module alarm_ctrl_fsm
  import alarm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       key_valid,
  output logic [3:0] key_ms_hr,
  output logic [3:0] key_ls_hr,
  output logic [3:0] key_ms_min,
  output logic [3:0] key_ls_min,
  output logic       load_new_c,
  output logic       load_new_a,
  output logic       show_new_time,
  output logic       show_alarm,
  output logic       entry_error
);

  state_e state_q, state_d;
  logic   load_c_q, load_c_d, load_a_q, load_a_d, err_q, err_d;
  logic   show_new_q, show_new_d, show_alarm_q, show_alarm_d;
  logic   buf_clear, buf_shift, key_is_digit, key_is_cmd, entry_ok, timeout_hit;

  alarm_key_shreg u_shreg (
    .clk    (clk),
    .reset  (reset),
    .clear  (buf_clear),
    .shift  (buf_shift),
    .digit  (key),
    .ms_hr  (key_ms_hr),
    .ls_hr  (key_ls_hr),
    .ms_min (key_ms_min),
    .ls_min (key_ls_min)
  );

  assign key_is_digit = key <= 4'd9;
  assign key_is_cmd   = (key == KEY_ALARM) || (key == KEY_TIME);
  assign entry_ok     = time_valid(key_ms_hr, key_ls_hr, key_ms_min, key_ls_min);

`ifdef ALARM_CTRL_TIMEOUT_EN
  logic [3:0] idle_cnt_q, idle_cnt_d;

  // Idle-second counter; any key or sitting in time display keeps it at zero.
  always_comb begin
    idle_cnt_d  = idle_cnt_q;
    timeout_hit = 1'b0;
    if (key_valid || (state_q == StShowTime)) begin
      idle_cnt_d = '0;
    end else if (one_second) begin
      if (idle_cnt_q == 4'(TIMEOUT_SECS - 1)) begin
        timeout_hit = 1'b1;
        idle_cnt_d  = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + 4'd1;
      end
    end
  end
`else
  logic unused_one_second;
  assign unused_one_second = one_second;
  assign timeout_hit       = 1'b0;
`endif

  // Next state, buffer control and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    buf_clear = 1'b0;
    buf_shift = 1'b0;
    load_c_d  = 1'b0;
    load_a_d  = 1'b0;
    err_d     = 1'b0;
    if (key_valid) begin
      unique case (state_q)
        StShowTime: begin
          if (key_is_digit) begin
            buf_clear = 1'b1;
            buf_shift = 1'b1;
            state_d   = StKeyEntry;
          end else if (key == KEY_ALARM) begin
            state_d = StShowAlarm;
          end
        end
        StKeyEntry: begin
          if (key_is_digit) begin
            buf_shift = 1'b1;
          end else if (key_is_cmd) begin
            load_c_d = entry_ok && (key == KEY_TIME);
            load_a_d = entry_ok && (key == KEY_ALARM);
            err_d    = !entry_ok;
            state_d  = StShowTime;
          end
        end
        StShowAlarm: begin
          if (key_is_cmd) state_d = StShowTime;
        end
        default: state_d = StShowTime;
      endcase
    end else if (timeout_hit) begin
      state_d = StShowTime;
    end
    show_new_d   = state_d == StKeyEntry;
    show_alarm_d = state_d == StShowAlarm;
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StShowTime;
      load_c_q     <= 1'b0;
      load_a_q     <= 1'b0;
      err_q        <= 1'b0;
      show_new_q   <= 1'b0;
      show_alarm_q <= 1'b0;
`ifdef ALARM_CTRL_TIMEOUT_EN
      idle_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      load_c_q     <= load_c_d;
      load_a_q     <= load_a_d;
      err_q        <= err_d;
      show_new_q   <= show_new_d;
      show_alarm_q <= show_alarm_d;
`ifdef ALARM_CTRL_TIMEOUT_EN
      idle_cnt_q   <= idle_cnt_d;
`endif
    end
  end

  assign load_new_c    = load_c_q;
  assign load_new_a    = load_a_q;
  assign entry_error   = err_q;
  assign show_new_time = show_new_q;
  assign show_alarm    = show_alarm_q;

endmodule
